// File: rtl/tx_serializer_if.sv
// Parallel-in handshake and serial-out status bundle for tx_serializer.
interface tx_serializer_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] par_data;
  logic              par_valid;
  logic              par_ready;
  logic              serial_out;
  logic              word_start;
  logic              underrun;
  logic              busy;

  modport master (
    output par_data, par_valid,
    input  par_ready, serial_out, word_start, underrun, busy
  );

  modport slave (
    input  par_data, par_valid,
    output par_ready, serial_out, word_start, underrun, busy
  );
endinterface

// File: rtl/tx_serializer.sv
// Parallel-to-serial transmitter with a one-word holding register and back-to-back words.
// Optional macro SER_IDLE_FILL_EN: on underrun keep shifting IDLE_WORD instead of going idle.
module tx_serializer #(
  parameter int              DATA_W    = 10,
  parameter bit              LSB_FIRST = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  tx_serializer_if.slave ser
);
  // state   | meaning
  // S_IDLE  | nothing on the line; serial_out 0, waiting for a held word
  // S_SHIFT | a word (data or idle fill) is being shifted out, cnt = bits left after this one

`ifdef SER_IDLE_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  localparam int              CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                underrun_q, underrun_d;
  logic                at_boundary;
  logic                take_hold;
  logic                accept;

  // A word boundary is any edge in IDLE or the last-bit edge in SHIFT.
  assign at_boundary   = (state_q == S_IDLE) || (cnt_q == '0);
  assign take_hold     = at_boundary && hold_full_q;
  assign ser.par_ready = !hold_full_q || at_boundary;
  assign accept        = ser.par_valid && ser.par_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    underrun_d  = 1'b0;
    hold_d      = accept ? ser.par_data : hold_q;
    hold_full_d = accept || (hold_full_q && !take_hold);
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          shift_d = hold_q;
          cnt_d   = CNT_TOP;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          shift_d = LSB_FIRST ? {1'b0, shift_q[DATA_W-1:1]} : {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
        end else if (hold_full_q) begin
          shift_d = hold_q;
          cnt_d   = CNT_TOP;
        end else begin
          // Underrun: either fill with the idle pattern or drop back to a quiet line.
          underrun_d = 1'b1;
          shift_d    = FILL_EN ? IDLE_WORD : '0;
          cnt_d      = FILL_EN ? CNT_TOP : '0;
          state_d    = FILL_EN ? S_SHIFT : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ser.serial_out = LSB_FIRST ? shift_q[0] : shift_q[DATA_W-1];
  assign ser.word_start = (state_q == S_SHIFT) && (cnt_q == CNT_TOP);
  assign ser.busy       = (state_q == S_SHIFT);
  assign ser.underrun   = underrun_q;

endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: MSB-first and LSB-first instances share stimulus and a word-level model.
module tb_tx_serializer;
  localparam int            DW     = 10;
  localparam logic [DW-1:0] IDLE_W = 10'b0101111100;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          par_valid = 1'b0;
  logic [DW-1:0] par_data  = '0;

  int n_pass  = 0;
  int n_total = 0;

  tx_serializer_if #(.DATA_W(DW)) if_a ();
  tx_serializer_if #(.DATA_W(DW)) if_b ();

  assign if_a.par_valid = par_valid;
  assign if_a.par_data  = par_data;
  assign if_b.par_valid = par_valid;
  assign if_b.par_data  = par_data;

  tx_serializer #(.DATA_W(DW), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE_W)) u_msb (
    .clk(clk), .reset_n(reset_n), .ser(if_a)
  );
  tx_serializer #(.DATA_W(DW), .LSB_FIRST(1'b1), .IDLE_WORD(IDLE_W)) u_lsb (
    .clk(clk), .reset_n(reset_n), .ser(if_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Word-level model: the word on the line, how many of its bits have gone, and a pending queue.
  bit            m_active = 1'b0;
  int            m_pos    = 0;
  logic [DW-1:0] m_word   = '0;
  logic [DW-1:0] m_hold[$];
  bit            m_ur     = 1'b0;

  function automatic bit m_ready();
    return (m_hold.size() == 0) || !m_active || (m_pos == DW - 1);
  endfunction

  function automatic logic [4:0] m_expect(input bit lsb_first);
    logic bit_o;
    bit_o = 1'b0;
    if (m_active) bit_o = lsb_first ? m_word[m_pos] : m_word[DW-1-m_pos];
    return {bit_o, m_active && (m_pos == 0), m_ur, m_active, m_ready()};
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 1'b0;
        m_pos    = 0;
        m_word   = '0;
        m_ur     = 1'b0;
        m_hold.delete();
      end else begin
        acc  = par_valid && m_ready();
        m_ur = 1'b0;
        if (!m_active || m_pos == DW - 1) begin
          if (m_hold.size() > 0) begin
            m_word   = m_hold.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
          end else if (m_active) begin
            m_ur = 1'b1;
`ifdef SER_IDLE_FILL_EN
            m_word = IDLE_W;
            m_pos  = 0;
`else
            m_active = 1'b0;
`endif
          end
        end else begin
          m_pos++;
        end
        if (acc) m_hold.push_back(par_data);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("stream_msb", {if_a.serial_out, if_a.word_start, if_a.underrun, if_a.busy, if_a.par_ready},
          m_expect(1'b0));
      chk("stream_lsb", {if_b.serial_out, if_b.word_start, if_b.underrun, if_b.busy, if_b.par_ready},
          m_expect(1'b1));
    end
  end

  // Called on a negedge; returns on the negedge just after the handshake edge.
  task automatic push(input logic [DW-1:0] w, output int waited);
    waited    = 0;
    par_valid = 1'b1;
    par_data  = w;
    while (!if_a.par_ready && waited < 50) begin
      par_data = w ^ (10'h155 + DW'(waited));
      @(negedge clk);
      waited++;
    end
    chk("push_ready", if_a.par_ready, 1'b1);
    par_data = w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    par_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int            w;
    logic [DW-1:0] seq;

    #1;
    chk("reset_outs_msb", {if_a.serial_out, if_a.word_start, if_a.underrun, if_a.busy, if_a.par_ready}, 5'b00001);
    chk("reset_outs_lsb", {if_b.serial_out, if_b.word_start, if_b.underrun, if_b.busy, if_b.par_ready}, 5'b00001);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single word MSB first, then underrun.
    seq = 10'b1100000101;
    push(10'b1100000101, w);
    par_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      chk("single_bit", if_a.serial_out, seq[DW-1-i]);
      chk("single_ws", if_a.word_start, (i == 0));
    end
    @(negedge clk);
    chk("single_underrun", if_a.underrun, 1'b1);
`ifdef SER_IDLE_FILL_EN
    chk("fill_busy", if_a.busy, 1'b1);
    chk("fill_ws", if_a.word_start, 1'b1);
    chk("fill_bit0", if_a.serial_out, 1'b0);
`else
    chk("idle_busy", if_a.busy, 1'b0);
    chk("idle_bit", if_a.serial_out, 1'b0);
`endif
    @(negedge clk);
    chk("underrun_pulse_end", if_a.underrun, 1'b0);

    // Back-to-back words, second accepted on the load edge of the first.
    do_reset();
    push(10'h3FF, w);
    push(10'h000, w);
    chk("b2b_no_wait", w, 0);
    par_valid = 1'b0;
    for (int i = 0; i < 2 * DW; i++) begin
      chk("b2b_bit", if_a.serial_out, (i < DW));
      chk("b2b_ws", if_a.word_start, (i % DW == 0));
      @(negedge clk);
    end
    chk("b2b_underrun", if_a.underrun, 1'b1);

    // LSB-first instance.
    do_reset();
    seq = 10'b1100000000;
    push(10'b0000000011, w);
    par_valid = 1'b0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      chk("lsb_bit", if_b.serial_out, seq[DW-1-i]);
    end

    // Stalled handshake with toggling data while the hold register is full.
    do_reset();
    push(10'h2C7, w);
    push(10'h135, w);
    chk("stall_ready_low", if_a.par_ready, 1'b0);
    push(10'h0F0, w);
    chk("stall_wait", w, 9);
    par_valid = 1'b0;
    repeat (40) @(negedge clk);

    // Word arriving exactly at the boundary edge with the hold register empty.
    do_reset();
    push(10'h1A5, w);
    par_valid = 1'b0;
    repeat (DW) @(negedge clk);
    push(10'h25A, w);
    par_valid = 1'b0;
    chk("boundary_underrun", if_a.underrun, 1'b1);
    repeat (25) @(negedge clk);

    // Reset mid-word with a second word held.
    do_reset();
    push(10'h3A6, w);
    push(10'h15B, w);
    par_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_msb", {if_a.serial_out, if_a.word_start, if_a.underrun, if_a.busy, if_a.par_ready}, 5'b00001);
    chk("midreset_lsb", {if_b.serial_out, if_b.word_start, if_b.underrun, if_b.busy, if_b.par_ready}, 5'b00001);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {if_a.serial_out, if_a.busy, if_b.serial_out, if_b.busy}, 4'b0000);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
